// File: rtl/serial_rx_ctrl.sv
// serial_rx_ctrl: frame controller for the battleship serial receive link.
// Oversamples rx, qualifies the start bit, steers the external
// serial_to_parallel shifter through `sample`, checks the stop bit and
// presents the byte to game logic over a valid/ack handshake.
`timescale 1ns/1ps

module serial_rx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int MID        = 7,
    parameter int DATA_BITS  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic [7:0] par_in,
    output logic       data,
    output logic [3:0] sample,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    input  logic       byte_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [3:0] PH_MID   = 4'(MID);
    localparam logic [3:0] PH_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);

    state_t     state_q, state_d;
    logic [3:0] phase_q, phase_d;
    logic [3:0] bitcnt_q, bitcnt_d;
    logic       rx_meta_q, rx_meta_d;
    logic       rx_s_q, rx_s_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       byte_valid_q, byte_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;

    logic       at_mid;
    logic [3:0] phase_next;

    // Bit-centre strobe and the wrapping phase increment shared by all active states.
    assign at_mid     = (phase_q == PH_MID);
    assign phase_next = (phase_q == PH_LAST) ? 4'd0 : phase_q + 4'd1;

    // Next-state, phase/bit counting, byte capture and handshake bookkeeping.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        bitcnt_d     = bitcnt_q;
        rx_meta_d    = rx;
        rx_s_d       = rx_meta_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_d = byte_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = overrun_q;

        // Consumer ack; a completing good frame below re-asserts valid.
        if (byte_valid_q && byte_ack) begin
            byte_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                phase_d = 4'd0;
                // The detection cycle counts as phase 0.
                if (!rx_s_q) begin
                    state_d = START;
                    phase_d = 4'd1;
                end
            end
            START: begin
                phase_d = phase_next;
                if (at_mid) begin
                    if (!rx_s_q) begin
                        state_d  = DATA;
                        bitcnt_d = 4'd0;
                    end else begin
                        // Line went back high before mid-bit: treat as a glitch.
                        state_d = IDLE;
                        phase_d = 4'd0;
                    end
                end
            end
            DATA: begin
                phase_d = phase_next;
                if (at_mid) begin
                    if (bitcnt_q == BIT_LAST) begin
                        state_d  = STOP;
                        bitcnt_d = 4'd0;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                phase_d = phase_next;
                if (at_mid) begin
                    // Leave at the stop-bit centre so a back-to-back start edge is caught.
                    state_d = IDLE;
                    phase_d = 4'd0;
                    if (rx_s_q) begin
                        rx_byte_d    = par_in;
                        byte_valid_d = 1'b1;
                        if (byte_valid_q && !byte_ack) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = 4'd0;
            end
        endcase
    end

    // State and datapath registers; reset also aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            phase_q      <= 4'd0;
            bitcnt_q     <= 4'd0;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_byte_q    <= 8'd0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            bitcnt_q     <= bitcnt_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            rx_byte_q    <= rx_byte_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // Shifter phase is only exposed during data bits so start/stop are never captured.
    assign sample     = (state_q == DATA) ? phase_q : 4'b0000;
    assign data       = rx_s_q;
    assign busy       = (state_q != IDLE);
    assign rx_byte    = rx_byte_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Directed bench for serial_rx_ctrl. Cycle numbers are posedge counts; a
// line edge driven in cycle n reaches rx_s two edges later, so detection
// cycle D = n + 2 and all expected timings are written relative to D.
`timescale 1ns/1ps

module tb_serial_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] par_in;
    logic       data;
    logic [3:0] sample;
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       byte_ack;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int s7_q[$];
    int fe_q[$];

    serial_rx_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .par_in     (par_in),
        .data       (data),
        .sample     (sample),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .byte_ack   (byte_ack),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    // 100 MHz clock and posedge counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record cycles of capture strobes and framing-error pulses.
    always @(negedge clk) begin
        if (sample == 4'd7) s7_q.push_back(cyc);
        if (frame_err) fe_q.push_back(cyc);
    end

    // Guard against a stuck run.
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Advance to just after the posedge that starts cycle t.
    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    // Drives start, 8 data bits LSB first and the stop bit, 16 cycles each.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] line;
        line = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = line[i];
            repeat (16) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    int n0;
    int d0;
    int n1;
    int d1;

    initial begin
        reset    = 1'b1;
        rx       = 1'b1;
        par_in   = 8'h00;
        byte_ack = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // 1: idle line after reset
        fe_q.delete();
        idle(50);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sample", 32'(sample), 0);
        chk("rst_valid", 32'(byte_valid), 0);
        chk("rst_rx_byte", 32'(rx_byte), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_data", 32'(data), 1);
        chk("rst_no_ferr", 32'(fe_q.size()), 0);

        // 2: good frame A5, ack at D+160
        idle(5);
        n0 = cyc; d0 = n0 + 2;
        par_in = 8'hA5;
        s7_q.delete(); fe_q.delete();
        fork
            begin
                send_frame(8'hA5, 1'b1);
                rx = 1'b1;
            end
            begin
                goto(d0 + 1);
                @(negedge clk);
                chk("busy_after_det", 32'(busy), 1);
                goto(d0 + 7);
                @(negedge clk);
                chk("start_gated_sample", 32'(sample), 0);
                goto(d0 + 8);
                @(negedge clk);
                chk("first_data_phase", 32'(sample), 8);
                goto(d0 + 151);
                @(negedge clk);
                chk("stop_chk_busy", 32'(busy), 1);
                chk("stop_chk_valid", 32'(byte_valid), 0);
                goto(d0 + 152);
                @(negedge clk);
                chk("good_valid", 32'(byte_valid), 1);
                chk("good_byte", 32'(rx_byte), 32'hA5);
                chk("good_busy_off", 32'(busy), 0);
                goto(d0 + 160);
                byte_ack = 1'b1;
                @(negedge clk);
                chk("valid_before_ack", 32'(byte_valid), 1);
                @(posedge clk);
                #1;
                byte_ack = 1'b0;
                @(negedge clk);
                chk("valid_after_ack", 32'(byte_valid), 0);
            end
        join
        chk("s7_count", 32'(s7_q.size()), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("s7_cycle_%0d", i), (i < s7_q.size()) ? 32'(s7_q[i]) : 32'hFFFFFFFF,
                32'(d0 + 23 + 16 * i));
        end
        chk("good_no_ferr", 32'(fe_q.size()), 0);

        // 3: 4-cycle glitch is rejected at the start check
        idle(20);
        n0 = cyc; d0 = n0 + 2;
        s7_q.delete(); fe_q.delete();
        rx = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rx = 1'b1;
        goto(d0 + 7);
        @(negedge clk);
        chk("glitch_busy_at_chk", 32'(busy), 1);
        goto(d0 + 8);
        @(negedge clk);
        chk("glitch_back_idle", 32'(busy), 0);
        goto(d0 + 60);
        chk("glitch_no_s7", 32'(s7_q.size()), 0);
        chk("glitch_no_ferr", 32'(fe_q.size()), 0);
        chk("glitch_valid", 32'(byte_valid), 0);

        // 4: low stop bit gives a one-cycle frame_err and no byte
        idle(20);
        n0 = cyc; d0 = n0 + 2;
        par_in = 8'h77;
        fe_q.delete();
        fork
            begin
                send_frame(8'h77, 1'b0);
                rx = 1'b1;
            end
            begin
                goto(d0 + 151);
                @(negedge clk);
                chk("ferr_before", 32'(frame_err), 0);
                goto(d0 + 152);
                @(negedge clk);
                chk("ferr_pulse", 32'(frame_err), 1);
                chk("ferr_valid", 32'(byte_valid), 0);
                chk("ferr_byte_kept", 32'(rx_byte), 32'hA5);
                goto(d0 + 153);
                @(negedge clk);
                chk("ferr_after", 32'(frame_err), 0);
            end
        join
        chk("ferr_count", 32'(fe_q.size()), 1);
        // The low stop bit looks like a fresh start edge; clear that frame.
        do_reset();

        // 5a: back-to-back frames, no ack -> overrun
        idle(20);
        par_in = 8'h3C;
        send_frame(8'h3C, 1'b1);
        par_in = 8'hC3;
        send_frame(8'hC3, 1'b1);
        idle(10);
        @(negedge clk);
        chk("b2b_byte", 32'(rx_byte), 32'hC3);
        chk("b2b_valid", 32'(byte_valid), 1);
        chk("b2b_overrun", 32'(overrun), 1);

        // 5b: same, with ack in the second completion cycle -> no overrun
        do_reset();
        idle(20);
        n0 = cyc; d1 = n0 + 2 + 160;
        fork
            begin
                par_in = 8'h3C;
                send_frame(8'h3C, 1'b1);
                par_in = 8'hC3;
                send_frame(8'hC3, 1'b1);
                rx = 1'b1;
            end
            begin
                goto(d1 + 151);
                byte_ack = 1'b1;
                @(posedge clk);
                #1;
                byte_ack = 1'b0;
                goto(d1 + 153);
                @(negedge clk);
                chk("ack_cmpl_byte", 32'(rx_byte), 32'hC3);
                chk("ack_cmpl_valid", 32'(byte_valid), 1);
                chk("ack_cmpl_overrun", 32'(overrun), 0);
            end
        join

        // 6: reset mid-frame, then a clean frame
        idle(20);
        n0 = cyc; d0 = n0 + 2;
        par_in = 8'h11;
        s7_q.delete();
        fork
            begin
                send_frame(8'hFF, 1'b1);
                rx = 1'b1;
            end
            begin
                goto(d0 + 60);
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                @(negedge clk);
                chk("midrst_sample", 32'(sample), 0);
                chk("midrst_busy", 32'(busy), 0);
                chk("midrst_valid", 32'(byte_valid), 0);
            end
        join
        idle(20);
        chk("midrst_s7_count", 32'(s7_q.size()), 3);
        chk("midrst_stays_idle", 32'(busy), 0);
        n1 = cyc; d1 = n1 + 2;
        par_in = 8'h5A;
        send_frame(8'h5A, 1'b1);
        rx = 1'b1;
        goto(d1 + 152);
        @(negedge clk);
        chk("post_rst_valid", 32'(byte_valid), 1);
        chk("post_rst_byte", 32'(rx_byte), 32'h5A);
        chk("post_rst_overrun", 32'(overrun), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_rx_ctrl.md
Name: serial_rx_ctrl

Overview:
Frame controller for the battleship serial receive link. It oversamples the incoming line, detects and validates a start bit, and drives the `sample` phase to `serial_to_parallel` so that exactly 8 data bits are captured at bit centres. It then checks the stop bit and hands the assembled byte to game logic through a valid/ack handshake, with framing-error and overrun reporting.

Parameters:
OVERSAMPLE  16  clock cycles per serial bit; must be ≤16, since `sample` is 4 bits
MID  7  phase at which a bit is sampled (4'b0111); must satisfy 1 ≤ MID ≤ OVERSAMPLE-1
DATA_BITS  8  data bits per frame

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
rx  input  1  raw serial line; idles high
par_in  input  8  parallel output of serial_to_parallel
data  output  1  synchronized rx bit, fed to the serial_to_parallel data input
sample  output  4  bit phase, fed to serial_to_parallel; the shifter captures when sample==MID
rx_byte  output  8  last good received byte
byte_valid  output  1  rx_byte holds an unconsumed byte
byte_ack  input  1  consumer accepts rx_byte
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  sticky: a byte completed while byte_valid=1 and byte_ack=0
busy  output  1  state != IDLE

Behaviour:
- Synchronizer: rx passes through 2 flops to produce rx_s; data = rx_s. Reset presets both flops to 1.
- Reset (sync, active-high, overrides everything, including mid-frame):
  - state=IDLE, phase=0, bitcnt=0.
  - rx_byte=0, byte_valid=0, frame_err=0, overrun=0, busy=0, sample=0.
- sample = phase when state==DATA, else 4'b0000. This gating stops the shifter capturing during start/stop bits.
- phase counts 0..OVERSAMPLE-1 and wraps to 0 in START/DATA/STOP. It is held at 0 in IDLE.
- States:
  - IDLE: when rx_s==0, that cycle is phase 0; next cycle state=START, phase=1.
  - START: at phase==MID:
    - rx_s==0 → DATA, bitcnt=0.
    - rx_s==1 → IDLE (glitch rejected; no error flagged).
  - DATA: at each phase==MID the shifter captures and bitcnt increments. When bitcnt reaches DATA_BITS-1 at MID → STOP.
  - STOP: at phase==MID:
    - rx_s==1 → rx_byte<=par_in, byte_valid<=1.
    - rx_s==0 → frame_err pulses for 1 cycle; byte discarded; rx_byte and byte_valid unchanged.
    - Either case → IDLE.
- Timing, with detection cycle D:
  - Start check at D+7.
  - Data bit i (0..7) sampled at D+7+16(i+1).
  - Stop check at D+151.
  - byte_valid and rx_byte visible at D+152.
- par_in must be stable from the last DATA capture until the STOP check (16 cycles). The controller issues no capture in that window.
- Handshake:
  - byte_ack with byte_valid=1 clears byte_valid next cycle.
  - byte_ack with byte_valid=0 is ignored.
- Simultaneous good-stop completion and byte_ack: the new byte is loaded, byte_valid stays 1, no overrun.
- Completion while byte_valid=1 and no ack: rx_byte is overwritten with the new byte, byte_valid stays 1, overrun<=1. overrun clears only on reset.
- Back-to-back frames: IDLE is re-entered at the stop-bit centre, so a start edge immediately after the stop bit is detected.
- busy is high from the cycle after detection through the STOP-check cycle, inclusive.

Test Plan:
1. Reset, rx held high for 50 cycles → busy=0, sample=0, byte_valid=0, no frame_err.
2. Good frame, par_in tied to 8'hA5, 16-cycle bits, stop=1:
   - sample==7 appears exactly 8 times, at D+23 through D+135 in steps of 16.
   - byte_valid rises at D+152 with rx_byte=8'hA5.
   - byte_ack at D+160 → byte_valid=0 at D+161.
3. rx low for only 4 cycles, then high → START aborts at D+7, back to IDLE, no sample==7 pulse, no frame_err.
4. Frame with stop bit 0 → frame_err high for exactly 1 cycle at D+152; byte_valid stays 0; rx_byte unchanged.
5. Two back-to-back good frames, par_in 8'h3C then 8'hC3, no ack → rx_byte=8'hC3, byte_valid=1, overrun=1. Repeat with ack asserted in the second completion cycle → overrun=0.
6. reset asserted at D+60 mid-frame → next cycle state IDLE, sample=0, busy=0. Rest of the frame ignored; next frame received correctly.
